// File: rtl/scoot_pkg.sv
// Shared types and constants for the scoot_mover grid walker: FSM states,
// committed-direction encoding and dir_in request bit positions.
package scoot_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_RESOLVE,
        ST_STEP,
        ST_DONE
    } state_e;

    localparam logic [1:0] DIR_UP    = 2'd0;
    localparam logic [1:0] DIR_LEFT  = 2'd1;
    localparam logic [1:0] DIR_DOWN  = 2'd2;
    localparam logic [1:0] DIR_RIGHT = 2'd3;

    localparam int BIT_UP    = 0;
    localparam int BIT_LEFT  = 1;
    localparam int BIT_DOWN  = 2;
    localparam int BIT_RIGHT = 3;

    // Consecutive no-move steps that end a run when stall abort is built in.
    localparam int STALL_LIMIT = 3;

endpackage

// File: rtl/scoot_dir_resolve.sv
// Turns a raw 4-bit request into a single direction: opposite pairs cancel,
// then up > left > down > right. valid_o low means no move.
module scoot_dir_resolve
    import scoot_pkg::*;
(
    input  logic [3:0] req_i,
    output logic       valid_o,
    output logic [1:0] dir_o
);

    logic [3:0] eff;

    always_comb begin
        eff = req_i;
        if (req_i[BIT_UP] && req_i[BIT_DOWN]) begin
            eff[BIT_UP]   = 1'b0;
            eff[BIT_DOWN] = 1'b0;
        end
        if (req_i[BIT_LEFT] && req_i[BIT_RIGHT]) begin
            eff[BIT_LEFT]  = 1'b0;
            eff[BIT_RIGHT] = 1'b0;
        end

        valid_o = 1'b1;
        dir_o   = DIR_UP;
        if (eff[BIT_UP])         dir_o = DIR_UP;
        else if (eff[BIT_LEFT])  dir_o = DIR_LEFT;
        else if (eff[BIT_DOWN])  dir_o = DIR_DOWN;
        else if (eff[BIT_RIGHT]) dir_o = DIR_RIGHT;
        else                     valid_o = 1'b0;
    end

endmodule

// File: rtl/scoot_mover.sv
// Grid walker: each timestep waits SETTLE_CYCLES, samples dir_in, resolves it
// and commits one wrapped move. Define SCOOT_MOVER_STALL_ABORT_EN to end a run
// after three consecutive no-move steps.
module scoot_mover
    import scoot_pkg::*;
#(
    parameter int GRID_W        = 10,
    parameter int GRID_H        = 10,
    parameter int SETTLE_CYCLES = 4,
    parameter int MAX_STEPS     = 200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [3:0] dir_in,
    output logic [3:0] pos_x,
    output logic [3:0] pos_y,
    output logic       move_valid,
    output logic [1:0] move_dir,
    output logic [7:0] step_cnt,
    output logic       busy,
    output logic       done,
    output logic       stalled
);

    localparam logic [3:0] X_MAX      = 4'(GRID_W - 1);
    localparam logic [3:0] Y_MAX      = 4'(GRID_H - 1);
    localparam logic [3:0] SETTLE_END = 4'(SETTLE_CYCLES - 1);
    localparam logic [7:0] STEPS_END  = 8'(MAX_STEPS);

    state_e     state_q;
    logic [3:0] settle_q;
    logic [3:0] dir_q;
    logic [3:0] pos_x_q, pos_y_q;
    logic [3:0] pos_x_d, pos_y_d;
    logic       move_valid_q;
    logic [1:0] move_dir_q;
    logic [7:0] step_cnt_q;
    logic       busy_q, done_q;
    logic       res_vld;
    logic [1:0] res_dir;
    logic       stall_hit;

    scoot_dir_resolve u_resolve (
        .req_i   (dir_q),
        .valid_o (res_vld),
        .dir_o   (res_dir)
    );

    always_comb begin
        pos_x_d = pos_x_q;
        pos_y_d = pos_y_q;
        if (res_vld) begin
            case (res_dir)
                DIR_UP:    pos_y_d = (pos_y_q == 4'd0)  ? Y_MAX : pos_y_q - 4'd1;
                DIR_LEFT:  pos_x_d = (pos_x_q == 4'd0)  ? X_MAX : pos_x_q - 4'd1;
                DIR_DOWN:  pos_y_d = (pos_y_q == Y_MAX) ? 4'd0  : pos_y_q + 4'd1;
                default:   pos_x_d = (pos_x_q == X_MAX) ? 4'd0  : pos_x_q + 4'd1;
            endcase
        end
    end

`ifdef SCOOT_MOVER_STALL_ABORT_EN
    logic [1:0] nomove_q;
    logic       stalled_q;
    assign stall_hit = (nomove_q == 2'(STALL_LIMIT));
    assign stalled   = stalled_q;
`else
    assign stall_hit = 1'b0;
    assign stalled   = 1'b0;
`endif

    // Move, pulse and count are committed on entry to STEP, so they are
    // visible during the STEP cycle itself.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            settle_q     <= 4'd0;
            dir_q        <= 4'd0;
            pos_x_q      <= 4'd0;
            pos_y_q      <= 4'd0;
            move_valid_q <= 1'b0;
            move_dir_q   <= DIR_UP;
            step_cnt_q   <= 8'd0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
`ifdef SCOOT_MOVER_STALL_ABORT_EN
            nomove_q     <= 2'd0;
            stalled_q    <= 1'b0;
`endif
        end else begin
            move_valid_q <= 1'b0;
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state_q    <= ST_SETTLE;
                        settle_q   <= 4'd0;
                        step_cnt_q <= 8'd0;
                        busy_q     <= 1'b1;
                        done_q     <= 1'b0;
`ifdef SCOOT_MOVER_STALL_ABORT_EN
                        nomove_q   <= 2'd0;
                        stalled_q  <= 1'b0;
`endif
                    end
                end
                ST_SETTLE: begin
                    if (settle_q == SETTLE_END) begin
                        dir_q    <= dir_in;
                        settle_q <= 4'd0;
                        state_q  <= ST_RESOLVE;
                    end else begin
                        settle_q <= settle_q + 4'd1;
                    end
                end
                ST_RESOLVE: begin
                    pos_x_q      <= pos_x_d;
                    pos_y_q      <= pos_y_d;
                    move_valid_q <= res_vld;
                    if (res_vld) move_dir_q <= res_dir;
                    step_cnt_q   <= step_cnt_q + 8'd1;
`ifdef SCOOT_MOVER_STALL_ABORT_EN
                    if (res_vld)         nomove_q <= 2'd0;
                    else if (!stall_hit) nomove_q <= nomove_q + 2'd1;
`endif
                    state_q      <= ST_STEP;
                end
                ST_STEP: begin
                    if (step_cnt_q == STEPS_END || stall_hit) begin
                        state_q   <= ST_DONE;
                        busy_q    <= 1'b0;
                        done_q    <= 1'b1;
`ifdef SCOOT_MOVER_STALL_ABORT_EN
                        stalled_q <= stall_hit;
`endif
                    end else begin
                        state_q   <= ST_SETTLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign pos_x      = pos_x_q;
    assign pos_y      = pos_y_q;
    assign move_valid = move_valid_q;
    assign move_dir   = move_dir_q;
    assign step_cnt   = step_cnt_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule

// File: tb/tb_scoot_mover.sv
// Bench for scoot_mover: timestep-level reference model checked every cycle,
// plus directed runs with hand-computed positions, counts and latencies.
module tb_scoot_mover;

    localparam int GW = 10;
    localparam int GH = 10;
    localparam int SC = 4;
    localparam int MS = 6;
`ifdef SCOOT_MOVER_STALL_ABORT_EN
    localparam bit STALL_EN = 1'b1;
`else
    localparam bit STALL_EN = 1'b0;
`endif
    localparam int NOMOVE_STEPS = STALL_EN ? 3 : MS;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [3:0] dir_in = 4'd0;
    logic [3:0] pos_x, pos_y;
    logic       move_valid;
    logic [1:0] move_dir;
    logic [7:0] step_cnt;
    logic       busy, done, stalled;

    always #5 clk = ~clk;

    scoot_mover #(
        .GRID_W(GW), .GRID_H(GH), .SETTLE_CYCLES(SC), .MAX_STEPS(MS)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .dir_in(dir_in),
        .pos_x(pos_x), .pos_y(pos_y), .move_valid(move_valid),
        .move_dir(move_dir), .step_cnt(step_cnt), .busy(busy),
        .done(done), .stalled(stalled)
    );

    int tests = 0;
    int fails = 0;

    task automatic chk(input string nm, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Direction from signed axis sums: up/left are negative, down/right positive.
    function automatic int pick(input logic [3:0] r);
        int v, h;
        v = int'(r[2]) - int'(r[0]);
        h = int'(r[3]) - int'(r[1]);
        if (v < 0) return 0;
        if (h < 0) return 1;
        if (v > 0) return 2;
        if (h > 0) return 3;
        return -1;
    endfunction

    function automatic int dx(input int d);
        return (d == 1) ? -1 : (d == 3) ? 1 : 0;
    endfunction

    function automatic int dy(input int d);
        return (d == 0) ? -1 : (d == 2) ? 1 : 0;
    endfunction

    // Timestep model: m_k is the index of the next clock edge within a step.
    bit         m_run = 0, m_busy = 0, m_done = 0, m_stalled = 0, m_mv = 0;
    int         m_k = 0, m_x = 0, m_y = 0, m_cnt = 0, m_mdir = 0, m_nomove = 0;
    logic [3:0] m_samp = 4'd0;
    int         m_pick;

    always_comb m_pick = pick(m_samp);

    always @(posedge clk) begin
        if (rst) begin
            m_run <= 0; m_busy <= 0; m_done <= 0; m_stalled <= 0; m_mv <= 0;
            m_k <= 0; m_x <= 0; m_y <= 0; m_cnt <= 0; m_mdir <= 0; m_nomove <= 0;
        end else if (!m_run) begin
            m_mv <= 0;
            if (start) begin
                m_run <= 1; m_busy <= 1; m_done <= 0; m_stalled <= 0;
                m_cnt <= 0; m_nomove <= 0; m_k <= 1;
            end
        end else begin
            if (m_k == SC) m_samp <= dir_in;
            if (m_k == SC + 1) begin
                m_cnt <= m_cnt + 1;
                if (m_pick >= 0) begin
                    m_mv     <= 1;
                    m_mdir   <= m_pick;
                    m_x      <= (m_x + dx(m_pick) + GW) % GW;
                    m_y      <= (m_y + dy(m_pick) + GH) % GH;
                    m_nomove <= 0;
                end else begin
                    m_nomove <= m_nomove + 1;
                end
            end
            if (m_k == SC + 2) begin
                m_mv <= 0;
                m_k  <= 1;
                if (m_cnt == MS || (STALL_EN && m_nomove >= 3)) begin
                    m_run     <= 0;
                    m_busy    <= 0;
                    m_done    <= 1;
                    m_stalled <= STALL_EN && m_nomove >= 3;
                end
            end else begin
                m_k <= m_k + 1;
            end
        end
    end

    bit armed = 0;

    always @(negedge clk) begin
        if (armed) begin
            chk("pos_x", int'(pos_x), m_x);
            chk("pos_y", int'(pos_y), m_y);
            chk("move_valid", int'(move_valid), int'(m_mv));
            chk("step_cnt", int'(step_cnt), m_cnt);
            chk("busy", int'(busy), int'(m_busy));
            chk("done", int'(done), int'(m_done));
            chk("stalled", int'(stalled), int'(m_stalled));
            if (m_mv) chk("move_dir", int'(move_dir), m_mdir);
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic do_start(input logic [3:0] d);
        dir_in = d;
        start  = 1'b1;
        tick();
        start  = 1'b0;
    endtask

    task automatic next_mv(input string nm);
        int n;
        n = 1;
        tick();
        while (!move_valid && n < 100) begin
            tick();
            n++;
        end
        chk({nm, "_mv_seen"}, int'(move_valid), 1);
    endtask

    task automatic wait_done(input string nm, output int mv_seen);
        int n;
        n = 0;
        mv_seen = 0;
        while (!done && n < 500) begin
            if (move_valid) mv_seen++;
            tick();
            n++;
        end
        chk({nm, "_done_seen"}, int'(done), 1);
    endtask

    logic [3:0] tog [3] = '{4'b0001, 4'b0010, 4'b0100};

    initial begin
        int n, mvs;
        rst = 1'b1;
        @(posedge clk);
        @(posedge clk);
        armed = 1;
        tick();
        chk("rst_pos_x", int'(pos_x), 0);
        chk("rst_pos_y", int'(pos_y), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_step_cnt", int'(step_cnt), 0);
        rst = 1'b0;
        tick();

        // Constant up: y wraps 0 -> 9 and keeps decrementing.
        do_start(4'b0001);
        n = 1;
        while (!move_valid && n < 100) begin tick(); n++; end
        chk("A_latency", n, SC + 2);
        chk("A_dir", int'(move_dir), 0);
        chk("A_y1", int'(pos_y), 9);
        start = 1'b1;              // must be ignored mid-run
        tick();
        start = 1'b0;
        next_mv("A2");
        chk("A_y2", int'(pos_y), 8);
        next_mv("A3");
        chk("A_y3", int'(pos_y), 7);
        wait_done("A", mvs);
        chk("A_cnt", int'(step_cnt), MS);
        chk("A_yend", int'(pos_y), 4);
        chk("A_busy", int'(busy), 0);

        // Left+right cancel: no moves, steps still counted.
        do_start(4'b1010);
        wait_done("B", mvs);
        chk("B_moves", mvs, 0);
        chk("B_cnt", int'(step_cnt), NOMOVE_STEPS);
        chk("B_x", int'(pos_x), 0);
        chk("B_y", int'(pos_y), 4);
        chk("B_stalled", int'(stalled), int'(STALL_EN));

        // All four cancel; then up+down cancel leaving left.
        do_start(4'b1111);
        wait_done("C0", mvs);
        chk("C0_moves", mvs, 0);
        do_start(4'b0111);
        next_mv("C1");
        chk("C1_dir", int'(move_dir), 1);
        chk("C1_x", int'(pos_x), 9);
        wait_done("C1", mvs);
        chk("C1_xend", int'(pos_x), 4);

        // dir_in toggles through SETTLE; only the final-cycle value counts.
        do_start(4'b0110);
        n = 1;
        for (int k = 1; k <= SC; k++) begin
            dir_in = (k == SC) ? 4'b1000 : tog[k % 3];
            tick();
            n++;
        end
        dir_in = 4'b0001;
        while (!move_valid && n < 100) begin tick(); n++; end
        chk("D_latency", n, SC + 2);
        chk("D_dir", int'(move_dir), 3);
        chk("D_x", int'(pos_x), 5);
        dir_in = 4'b1000;
        wait_done("D", mvs);
        chk("D_xend", int'(pos_x), 0);

        // Reset during STEP of step 5 aborts the run.
        do_start(4'b0100);
        n = 0;
        while (!(move_valid && step_cnt == 8'd5) && n < 500) begin tick(); n++; end
        chk("E_step5", int'(step_cnt), 5);
        chk("E_y5", int'(pos_y), 9);
        rst = 1'b1;
        tick();
        chk("E_rst_mv", int'(move_valid), 0);
        chk("E_rst_x", int'(pos_x), 0);
        chk("E_rst_y", int'(pos_y), 0);
        chk("E_rst_cnt", int'(step_cnt), 0);
        chk("E_rst_busy", int'(busy), 0);
        chk("E_rst_done", int'(done), 0);
        chk("E_rst_stalled", int'(stalled), 0);
        rst = 1'b0;
        tick();
        do_start(4'b0100);
        next_mv("E2");
        chk("E2_y", int'(pos_y), 1);
        chk("E2_x", int'(pos_x), 0);
        wait_done("E2", mvs);

        // No requests at all: stall abort or full-length run.
        do_start(4'b0000);
        wait_done("F", mvs);
        chk("F_cnt", int'(step_cnt), NOMOVE_STEPS);
        chk("F_stalled", int'(stalled), int'(STALL_EN));
        chk("F_busy", int'(busy), 0);
        tick();
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/scoot_mover.md
SCOOT_MOVER -- requirements
Module: scoot_mover

Interface
REQ-001 Parameter GRID_W, default 10, grid width in cells (2..16).
REQ-002 Parameter GRID_H, default 10, grid height in cells (2..16).
REQ-003 Parameter SETTLE_CYCLES, default 4, number of clocks dir_in is allowed to settle before sampling (1..15).
REQ-004 Parameter MAX_STEPS, default 200, number of timesteps per run (1..255).
REQ-005 clk  input  1  single clock; all state changes on rising edge.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 start  input  1  one-cycle pulse; begins a run when idle.
REQ-008 dir_in  input  4  controller request bits: [0] up, [1] left, [2] down, [3] right.
REQ-009 pos_x  output  4  current column, 0..GRID_W-1.
REQ-010 pos_y  output  4  current row, 0..GRID_H-1; up decrements.
REQ-011 move_valid  output  1  one-cycle pulse when a step is committed.
REQ-012 move_dir  output  2  committed direction, valid with move_valid: 0 up, 1 left, 2 down, 3 right.
REQ-013 step_cnt  output  8  timesteps completed this run.
REQ-014 busy  output  1  high from accepted start until done.
REQ-015 done  output  1  high in DONE, held until next accepted start.
REQ-016 stalled  output  1  run ended by stall abort (see Configuration).

Function
REQ-017 States: IDLE, SETTLE, RESOLVE, STEP, DONE.
REQ-018 IDLE: start=1 -> SETTLE; clears step_cnt, done, stalled; position retained.
REQ-019 SETTLE: counts SETTLE_CYCLES clocks, then -> RESOLVE; dir_in is sampled into a register on the last SETTLE cycle only.
REQ-020 RESOLVE: opposite pairs cancel (up+down both cleared, left+right both cleared); of remaining bits, priority up > left > down > right; no bit remaining = no-move.
REQ-021 STEP: one cycle; applies the move, pulses move_valid (not for no-move), increments step_cnt by 1 for every step including no-move.
REQ-022 STEP -> DONE when step_cnt reaches MAX_STEPS, else -> SETTLE.
REQ-023 Wrap-around: right at x=GRID_W-1 gives x=0; left at x=0 gives x=GRID_W-1; same rule on y with GRID_H.
REQ-024 Latency: start to first move_valid = SETTLE_CYCLES+2 clocks; step period = SETTLE_CYCLES+2 clocks.
REQ-025 start ignored outside IDLE and DONE; start in DONE behaves as in IDLE.
REQ-026 dir_in changes during SETTLE have no effect except the final sampled value.

Reset
REQ-027 rst=1 -> IDLE, pos_x=0, pos_y=0, step_cnt=0, move_valid=0, move_dir=0, busy=0, done=0, stalled=0, settle counter 0.
REQ-028 rst in any state aborts the run with no move_valid in that cycle; rst overrides start.

Configuration
REQ-029 Macro SCOOT_MOVER_STALL_ABORT_EN defined: 3 consecutive no-move steps -> DONE with stalled=1 after the third step's step_cnt increment.
REQ-030 Macro undefined: no stall detection, stalled tied to 0, runs always last MAX_STEPS.

Structure
REQ-031 Shared package scoot_pkg holds the state enum, direction encoding (0..3 constants) and the dir_in bit index constants.
REQ-032 One sub-module scoot_dir_resolve: combinational 4-bit request to valid+2-bit direction per REQ-020.

Verification
REQ-033 Reset, start, dir_in=4'b0001 constant, MAX_STEPS=3 -> pos_y 0->9->8->7, three move_valid with move_dir=0, done=1, step_cnt=3.
REQ-034 dir_in=4'b1010 (left+right) -> no move_valid, step_cnt increments, position unchanged.
REQ-035 dir_in=4'b1111 -> no move; dir_in=4'b0111 -> left cancelled? no: up+down cancel, left wins, move_dir=1, x 0->9.
REQ-036 dir_in toggled every cycle during SETTLE, final value 4'b1000 -> move_dir=3, x +1; first move_valid exactly SETTLE_CYCLES+2 clocks after start.
REQ-037 rst asserted in STEP of step 5 -> all outputs at reset values next cycle, no move_valid; new start resumes from (0,0).
REQ-038 With SCOOT_MOVER_STALL_ABORT_EN, dir_in=0 from start -> done=1, stalled=1, step_cnt=3; without macro -> step_cnt=MAX_STEPS, stalled=0.
